// File: rtl/bitwise_operand_assembler.sv
// bitwise_operand_assembler
//
// Collects a narrow W-bit beat stream into two N-bit operands (A first, then
// B) and presents the completed pair on registered a/b outputs for a
// downstream combinational BitWise unit (OR/AND/XOR).
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. in_ready and out_valid are decoded from the
// state register alone, so neither has a combinational path from any input.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears state, counter, a, b)
//   flush      synchronous abort of a partially loaded pair (a/b kept)
//   in_data    W-bit operand beat, little-endian by beat within an operand
//   in_valid   in_data valid
//   in_ready   block accepts a beat this cycle (LOAD_A or LOAD_B)
//   a, b       assembled operands, registered
//   out_valid  a/b hold a complete pair (HOLD)
//   out_ready  consumer accepts the pair
//
// The FSM state is held in state_q (type state_t) for checker binding.

module bitwise_operand_assembler #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int K  = N / W;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  generate
    if (N < 1 || W < 1 || (N % W) != 0) begin : g_bad_params
      $error("bitwise_operand_assembler: N must be >= 1 and a multiple of W");
    end
  endgenerate

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;

  logic          beat_accept;
  logic          last_beat;

  assign in_ready    = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign out_valid   = (state_q == HOLD);
  assign beat_accept = in_valid && in_ready;
  assign last_beat   = (cnt_q == CW'(K - 1));

  assign a = a_q;
  assign b = b_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;

    case (state_q)
      LOAD_A: begin
        if (beat_accept) begin
          a_d[int'(cnt_q)*W +: W] = in_data;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = LOAD_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (beat_accept) begin
          b_d[int'(cnt_q)*W +: W] = in_data;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        // a/b are deliberately left intact after the handshake.
        if (out_ready) begin
          state_d = LOAD_A;
        end
      end
      default: begin
        state_d = LOAD_A;
        cnt_d   = '0;
      end
    endcase

    // flush overrides the state/counter update but not the data write, so a
    // beat arriving alongside flush still lands at its current index.
    if (flush) begin
      state_d = LOAD_A;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

endmodule

// File: tb/tb_bitwise_operand_assembler.sv
module tb_bitwise_operand_assembler;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT N=8,W=4
  logic       flush;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;

  bitwise_operand_assembler #(.N(8), .W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // ---------------------------------------------------------------- DUT N=8,W=8 (K=1)
  logic       k1_flush;
  logic [7:0] k1_in_data;
  logic       k1_in_valid;
  logic       k1_in_ready;
  logic [7:0] k1_a;
  logic [7:0] k1_b;
  logic       k1_out_valid;
  logic       k1_out_ready;

  bitwise_operand_assembler #(.N(8), .W(8)) dut_k1 (
    .clk       (clk),
    .rst       (rst),
    .flush     (k1_flush),
    .in_data   (k1_in_data),
    .in_valid  (k1_in_valid),
    .in_ready  (k1_in_ready),
    .a         (k1_a),
    .b         (k1_b),
    .out_valid (k1_out_valid),
    .out_ready (k1_out_ready)
  );

  int checks;
  int errors;

  // Advance one clock; inputs are driven and outputs observed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one valid beat for one cycle (DUT is expected to be ready).
  task automatic drive_beat(input logic [3:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (a !== 8'h00 || b !== 8'h00) begin
      errors++;
      $display("FAIL reset_ab: a=%h b=%h expected a=00 b=00", a, b);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    checks++;
    if (k1_a !== 8'h00 || k1_b !== 8'h00 || k1_in_ready !== 1'b1 || k1_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_k1: a=%h b=%h in_ready=%b out_valid=%b expected 00/00/1/0",
               k1_a, k1_b, k1_in_ready, k1_out_valid);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_pair();
    int valid_cycles;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'h5; tick();
    in_data   = 4'hA; tick();
    in_data   = 4'h3; tick();
    in_data   = 4'hC; tick();
    in_valid  = 1'b0;
    // Now in the 5th cycle counted from the first beat's cycle.
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL pair_hold: out_valid=%b in_ready=%b expected 1/0", out_valid, in_ready);
    end
    checks++;
    if (a !== 8'hA5 || b !== 8'hC3) begin
      errors++;
      $display("FAIL pair_data: a=%h b=%h expected a=a5 b=c3", a, b);
    end
    checks++;
    if ((a | b) !== 8'hE7) begin
      errors++;
      $display("FAIL pair_or: a|b=%h expected e7", a | b);
    end
    valid_cycles = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid === 1'b1) valid_cycles++;
    end
    checks++;
    if (valid_cycles !== 1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL pair_one_cycle: out_valid cycles=%0d in_ready=%b expected 1 cycle, 1",
               valid_cycles, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    out_ready = 1'b0;
    drive_beat(4'h1);
    drive_beat(4'h2);
    drive_beat(4'h3);
    drive_beat(4'h4);
    bad = 0;
    in_valid = 1'b1;
    in_data  = 4'hF;
    for (int i = 0; i < 6; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || a !== 8'h21 || b !== 8'h43) bad++;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_hold: %0d bad cycles (out_valid=%b in_ready=%b a=%h b=%h) expected 0",
               bad, out_valid, in_ready, a, b);
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_still_valid: out_valid=%b expected 1", out_valid);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || a !== 8'h21 || b !== 8'h43) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b a=%h b=%h expected 0/1/21/43",
               out_valid, in_ready, a, b);
    end
  endtask

  task automatic test_valid_gaps();
    logic [3:0] beats [4];
    int bad;
    beats[0] = 4'h5; beats[1] = 4'hA; beats[2] = 4'h3; beats[3] = 4'hC;
    out_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      drive_beat(beats[i]);
      in_data = 4'h0;  // idle cycle with junk data, in_valid low
      if (i < 3 && (in_ready !== 1'b1 || out_valid !== 1'b0)) bad++;
      if (i < 3) tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL gaps_progress: %0d bad idle cycles expected 0", bad);
    end
    checks++;
    if (out_valid !== 1'b1 || a !== 8'hA5 || b !== 8'hC3) begin
      errors++;
      $display("FAIL gaps_data: out_valid=%b a=%h b=%h expected 1/a5/c3", out_valid, a, b);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive_beat(4'h1);
    drive_beat(4'h2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_state: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    drive_beat(4'h7);
    drive_beat(4'h8);
    drive_beat(4'h9);
    drive_beat(4'hF);
    checks++;
    if (out_valid !== 1'b1 || a !== 8'h87 || b !== 8'hF9) begin
      errors++;
      $display("FAIL flush_data: out_valid=%b a=%h b=%h expected 1/87/f9", out_valid, a, b);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_load();
    out_ready = 1'b0;
    drive_beat(4'h1);
    drive_beat(4'h2);
    drive_beat(4'h3);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'hE;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (a !== 8'h00 || b !== 8'h00 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: a=%h b=%h out_valid=%b in_ready=%b expected 00/00/0/1",
               a, b, out_valid, in_ready);
    end
    drive_beat(4'h6);
    drive_beat(4'h5);
    drive_beat(4'h4);
    drive_beat(4'h3);
    checks++;
    if (out_valid !== 1'b1 || a !== 8'h56 || b !== 8'h34) begin
      errors++;
      $display("FAIL rst_fresh_pair: out_valid=%b a=%h b=%h expected 1/56/34", out_valid, a, b);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_k1();
    logic [7:0] data [9];
    logic       exp_v [9];
    int bad;
    data[0] = 8'hF0; data[1] = 8'h0F; data[2] = 8'h00;
    data[3] = 8'h11; data[4] = 8'h22; data[5] = 8'h00;
    data[6] = 8'h33; data[7] = 8'h44; data[8] = 8'h00;
    for (int i = 0; i < 9; i++) exp_v[i] = (i % 3 == 2);
    k1_out_ready = 1'b1;
    k1_in_valid  = 1'b1;
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      if (k1_out_valid !== exp_v[i] || k1_in_ready !== !exp_v[i]) bad++;
      if (i == 2) begin
        checks++;
        if (k1_a !== 8'hF0 || k1_b !== 8'h0F) begin
          errors++;
          $display("FAIL k1_first_pair: a=%h b=%h expected f0/0f", k1_a, k1_b);
        end
      end
      if (i == 8) begin
        checks++;
        if (k1_a !== 8'h33 || k1_b !== 8'h44) begin
          errors++;
          $display("FAIL k1_third_pair: a=%h b=%h expected 33/44", k1_a, k1_b);
        end
      end
      k1_in_data = data[i];
      tick();
    end
    k1_in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL k1_cadence: %0d cycles off the 3-cycle pattern expected 0", bad);
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    flush        = 1'b0;
    in_data      = '0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    k1_flush     = 1'b0;
    k1_in_data   = '0;
    k1_in_valid  = 1'b0;
    k1_out_ready = 1'b0;

    test_reset();
    test_basic_pair();
    test_backpressure();
    test_valid_gaps();
    test_flush();
    test_reset_mid_load();
    test_k1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
